// File: rtl/cla_mul_seq.sv
// Iterative unsigned 32x32->64 shift-add multiplier.
// One add/shift step per cycle through a single 32-bit carry-lookahead adder.
// Operands arrive on a valid/ready input channel; the product leaves on a valid/ready output channel.

// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
module cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] s,
   output logic        cout
);

   logic [31:0] p;
   logic [31:0] g;
   logic [32:0] c;

   assign p = a ^ b;
   assign g = a & b;

   // Lookahead carries inside each group, group carry-out feeds the next group
   always_comb begin
      c    = '0;
      c[0] = cin;
      for (int unsigned k = 0; k < 8; k++) begin
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                  | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                  | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
      end
   end

   assign s    = p ^ c[31:0];
   assign cout = c[32];

endmodule

module cla_mul_seq #(
   parameter bit EARLY_EXIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] product_hi,
   output logic [31:0] product_lo,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t      state;
   state_t      state_nxt;

   logic [31:0] mcand;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mplier;
   logic [5:0]  cnt;

   logic        accept;
   logic [31:0] addend;
   logic [31:0] sum;
   logic        carry;
   logic [31:0] mplier_nxt;
   logic [5:0]  cnt_inc;
   logic [5:0]  shamt;
   logic [63:0] step;
   logic [63:0] step_res;
   logic        last;
   logic        early;

   assign accept = in_valid & in_ready;
   assign addend = lo[0] ? mcand : '0;

   // The adder's carry-out is exactly (hi[31]&addend[31]) | ((hi[31]|addend[31]) & ~sum[31])
   cla32 u_cla (
      .a    (hi),
      .b    (addend),
      .cin  (1'b0),
      .s    (sum),
      .cout (carry)
   );

   // One shift-add step; on early exit the remaining zero-add steps collapse into one right shift
   always_comb begin
      mplier_nxt = mplier >> 1;
      cnt_inc    = cnt + 6'd1;
      step       = {carry, sum, lo[31:1]};
      last       = (cnt_inc == 6'd32);
      early      = EARLY_EXIT && (mplier_nxt == '0);
      shamt      = early ? (6'd32 - cnt_inc) : '0;
      step_res   = step >> shamt;
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE:    state_nxt = accept ? RUN : IDLE;
         RUN:     state_nxt = (last || early) ? DONE : RUN;
         DONE:    state_nxt = out_ready ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         RUN:     busy      = 1'b1;
         DONE:    out_valid = 1'b1;
         default: in_ready  = 1'b1;
      endcase
   end

   // Datapath: operand load on accept, one step per RUN cycle, held through DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mcand  <= '0;
         hi     <= '0;
         lo     <= '0;
         mplier <= '0;
         cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mcand  <= a;
                  hi     <= '0;
                  lo     <= b;
                  mplier <= b;
                  cnt    <= '0;
               end
            end
            RUN: begin
               {hi, lo} <= step_res;
               mplier   <= mplier_nxt;
               cnt      <= cnt_inc;
            end
            default: ;
         endcase
      end
   end

   assign product_hi = hi;
   assign product_lo = lo;

endmodule

// File: tb/tb_cla_mul_seq.sv
// Directed and randomised checks of cla_mul_seq, one instance per EARLY_EXIT setting.
module tb_cla_mul_seq;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [1:0]       in_valid = '0;
   logic [1:0]       out_ready = '0;
   logic [1:0]       in_ready;
   logic [1:0]       out_valid;
   logic [1:0]       busy;
   logic [1:0][31:0] a_v = '0;
   logic [1:0][31:0] b_v = '0;
   logic [1:0][31:0] phi;
   logic [1:0][31:0] plo;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cla_mul_seq #(.EARLY_EXIT(1'b0)) dut0 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[0]),
      .in_ready   (in_ready[0]),
      .a          (a_v[0]),
      .b          (b_v[0]),
      .out_valid  (out_valid[0]),
      .out_ready  (out_ready[0]),
      .product_hi (phi[0]),
      .product_lo (plo[0]),
      .busy       (busy[0])
   );

   cla_mul_seq #(.EARLY_EXIT(1'b1)) dut1 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[1]),
      .in_ready   (in_ready[1]),
      .a          (a_v[1]),
      .b          (b_v[1]),
      .out_valid  (out_valid[1]),
      .out_ready  (out_ready[1]),
      .product_hi (phi[1]),
      .product_lo (plo[1]),
      .busy       (busy[1])
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h, expected 0x%h", tag, obs, exp);
      end
   endtask

   function automatic int exp_lat(input bit ee, input logic [31:0] b);
      if (!ee) return 32;
      for (int i = 31; i >= 0; i--) begin
         if (b[i]) return i + 1;
      end
      return 1;
   endfunction

   // One full transaction on instance d: accept, wait for DONE, hold `hold` cycles, handshake
   task automatic do_op(input int d, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [63:0] p_exp, input int hold,
                        input bit noise);
      int          cyc;
      bit          seen;
      check("idle_ready", in_ready[d], 1);
      in_valid[d] = 1'b1;
      a_v[d]      = a;
      b_v[d]      = b;
      @(posedge clk); #1;
      in_valid[d] = 1'b0;
      a_v[d]      = $urandom;
      b_v[d]      = $urandom;
      check("busy_run", busy[d], 1);
      check("ready_run", in_ready[d], 0);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 100) begin
         if (noise) begin
            in_valid[d]  = 1'($urandom_range(0, 1));
            out_ready[d] = 1'($urandom_range(0, 1));
         end
         @(posedge clk); #1;
         cyc++;
         seen = out_valid[d];
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      check("done_seen", seen, 1);
      if (!seen) return;
      check("latency", cyc, lat);
      check("product", {phi[d], plo[d]}, p_exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_product", {phi[d], plo[d]}, p_exp);
         check("hold_valid", out_valid[d], 1);
         check("hold_ready", in_ready[d], 0);
      end
      out_ready[d] = 1'b1;
      @(posedge clk); #1;
      out_ready[d] = 1'b0;
      check("drop_valid", out_valid[d], 0);
      check("back_idle", in_ready[d], 1);
   endtask

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          saw;
      logic [31:0] ra;
      logic [31:0] rb;

      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_in_ready", in_ready[d], 1);
         check("rst_out_valid", out_valid[d], 0);
         check("rst_busy", busy[d], 0);
         check("rst_product", {phi[d], plo[d]}, 64'h0);
      end
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed vectors, expected values computed by hand
      do_op(0, 32'd3, 32'd5, 32, 64'h00000000_0000000F, 0, 1'b0);
      do_op(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 64'hFFFFFFFE_00000001, 0, 1'b0);
      do_op(0, 32'h00001234, 32'h0, 32, 64'h0, 0, 1'b0);
      do_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 64'hFFFFFFFE_00000001, 0, 1'b0);
      do_op(1, 32'h12345678, 32'd5, 3, 64'h00000000_5B05B058, 0, 1'b0);
      do_op(1, 32'hDEADBEEF, 32'h0, 1, 64'h0, 0, 1'b0);
      do_op(1, 32'hFFFFFFFF, 32'h80000000, 32, 64'h7FFFFFFF_80000000, 0, 1'b0);
      do_op(1, 32'hFFFFFFFF, 32'h1, 1, 64'h00000000_FFFFFFFF, 0, 1'b0);
      do_op(1, 32'h7, 32'h100, 9, 64'h00000000_00000700, 0, 1'b0);
      // Backpressure: product held for 10 cycles
      do_op(1, 32'h12345678, 32'd5, 3, 64'h00000000_5B05B058, 10, 1'b0);
      do_op(0, 32'h12345678, 32'd5, 32, 64'h00000000_5B05B058, 10, 1'b0);

      // Reset during step 10 of RUN
      in_valid[0] = 1'b1;
      a_v[0]      = 32'h0BADF00D;
      b_v[0]      = 32'hFFFFFFFF;
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", out_valid[0], 0);
      check("midrst_busy", busy[0], 0);
      check("midrst_in_ready", in_ready[0], 1);
      check("midrst_product", {phi[0], plo[0]}, 64'h0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      saw = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (out_valid[0]) saw = 1'b1;
      end
      check("no_valid_after_rst", saw, 0);
      do_op(0, 32'h00010000, 32'h00010000, 32, 64'h00000001_00000000, 0, 1'b0);

      // Randomised operands, gaps and backpressure on both instances
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            do_op(d, ra, rb, exp_lat(d[0], rb), {32'h0, ra} * {32'h0, rb},
                  int'($urandom_range(0, 3)), 1'b1);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
